// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the countdown controller: default slice width and FSM state encoding.
package countdown_ctrl_pkg;

  localparam int CD_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1
  } state_e;

endpackage

// File: rtl/countdown_ctrl_dec_slice.sv
// Combinational ripple-borrow subtractor, diff_o = a_i - b_i - bin_i, built from full subtractors.
// Zero latency. No handshake: the output follows the inputs.
module dec_slice #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic [WIDTH-1:0] diff_o
);

  logic [WIDTH-1:0] borrow;

  assign borrow[0] = bin_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fs
    logic axb;
    assign axb       = a_i[i] ^ b_i[i];
    assign diff_o[i] = axb ^ borrow[i];
    // The borrow out of the top bit is never built: zero is never decremented.
    if (i < WIDTH - 1) begin : g_bo
      assign borrow[i+1] = (~a_i[i] & b_i[i]) | (~axb & borrow[i]);
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown sequencer: load, decrement per qualified tick, terminal-count pulse, optional reload.
// Latency: 1 cycle from start/terminal tick to busy/done. No backpressure; pause freezes the count.
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int WIDTH = CD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             tick_en,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             ovr,
  output logic [WIDTH-1:0] count
);

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             auto_q;
  logic             busy_q;
  logic             done_q;
  logic             ovr_q;
  logic [WIDTH-1:0] count_dec;
  logic             tick_ok;
  logic             at_last;

  dec_slice #(
    .WIDTH (WIDTH)
  ) u_dec (
    .a_i    (count_q),
    .b_i    ({WIDTH{1'b0}}),
    .bin_i  (1'b1),
    .diff_o (count_dec)
  );

  assign tick_ok = tick_en & ~pause;
  assign at_last = (count_q == WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      auto_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        // Abort beats a coincident terminal tick, so done stays low.
        state_q <= S_IDLE;
        count_q <= '0;
        busy_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (load_val != '0) begin
                state_q  <= S_COUNT;
                count_q  <= load_val;
                reload_q <= load_val;
                auto_q   <= auto_reload;
                busy_q   <= 1'b1;
              end else begin
                done_q  <= 1'b1;
                count_q <= '0;
              end
            end
          end
          S_COUNT: begin
            if (start) begin
              ovr_q <= 1'b1;
            end
            // count_q is never zero in COUNT, so !at_last means count_q > 1.
            if (tick_ok) begin
              if (!at_last) begin
                count_q <= count_dec;
              end else begin
                done_q <= 1'b1;
                if (auto_q) begin
                  count_q <= reload_q;
                end else begin
                  count_q <= '0;
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign ovr   = ovr_q;
  assign count = count_q;

endmodule
